mem_stage: RTL
==============

# mem_stage

Memory-access stage between the execute/memory pipeline register and the memory/writeback register. It accepts one instruction per handshake and resolves the branch decision from the zero/less-than flags. Loads and stores go through a single-outstanding valid/ready data-memory port. Load data is sign- or zero-extended, and the result is held in an output register until downstream accepts it.

## Interface
- `BranchType`, default 4: `I_Type_i` encoding that marks a conditional branch.
- `clk_i`  in  1  clock.
- `reset_i`  in  1  asynchronous, active-high reset.
- `valid_i` / `ready_o`  in/out  1  upstream handshake.
- `zero_i`, `ltz_i`  in  1  ALU flags.
- `BranchPC_i`  in  64  branch target.
- `result_i`  in  64  ALU result; this is the effective address for memory operations.
- `MuxRes_i`  in  64  store data.
- `rd_i`  in  5  destination register.
- `RegWrite_i`, `MemWrite_i`, `MemRead_i`, `MemToReg_i`  in  1  control bits.
- `funct3_i`  in  3  access size / branch condition.
- `I_Type_i`  in  3  instruction class.
- `pc_src_o`  out  1  branch taken; combinational.
- `branch_target_o`  out  64  equals `BranchPC_i`.
- `dmem_req_valid_o` / `dmem_req_ready_i`  out/in  1  memory request handshake.
- `dmem_we_o`  out  1  1 = store.
- `dmem_addr_o`  out  64  `{result[63:3], 3'b000}`.
- `dmem_wdata_o`  out  64  lane-shifted store data.
- `dmem_wstrb_o`  out  8  byte strobes.
- `dmem_rsp_valid_i`  in  1  load data valid.
- `dmem_rdata_i`  in  64  load doubleword.
- `valid_o` / `ready_i`  out/in  1  downstream handshake.
- `result_o`  out  64  ALU result.
- `read_data_o`  out  64  extended load data.
- `rd_o`  out  5  destination register.
- `RegWrite_o`, `MemToReg_o`  out  1  writeback control.
- `misaligned_o`  out  1  one-cycle pulse on a misaligned access.

## Operation
**States**
- IDLE: `ready_o` = 1.
- REQ: `dmem_req_valid_o` = 1.
- WAIT: awaiting the load response.
- OUT: `valid_o` = 1, `ready_o` = `ready_i`.

**Accept and dispatch**
- Accept = `valid_i & ready_o`.
- On accept, capture `result`, `rd`, `RegWrite`, `MemToReg`, `funct3`, `MuxRes` and address bits [2:0].
- Next state is REQ if `MemRead` or `MemWrite`; otherwise OUT.

**Request and response**
- REQ: hold `dmem_*` stable until `dmem_req_ready_i`.
- Store: REQ → OUT on request acceptance.
- Load: REQ → WAIT on request acceptance; WAIT → OUT on `dmem_rsp_valid_i`, capturing the extended data.
- `dmem_rsp_valid_i` is ignored in every state except WAIT.

**Output**
- OUT with `ready_i`: return to IDLE, or dispatch a simultaneously accepted new instruction (back-to-back).

**Branch resolution**
- `pc_src_o` = accept & (`I_Type_i` == `BranchType`) & cond.
- cond by `funct3`: 000 → `zero`; 001 → `!zero`; 100/110 → `ltz`; 101/111 → `!ltz`; 010/011 → 0.

**Load extension** (lane = addr[2:0])
- 000 sign-extended byte; 100 zero-extended byte.
- 001 sign-extended half; 101 zero-extended half.
- 010 sign-extended word; 110 zero-extended word.
- 011 doubleword; 111 treated as 011.

**Stores**
- Size from `funct3[1:0]`: 1, 2, 4 or 8 bytes.
- Strobe = size mask << addr[2:0].
- `wdata` = `MuxRes` << (8·addr[2:0]).

**Misalignment**
- Condition: addr not a multiple of the access size.
- No memory request is issued; `misaligned_o` pulses in the accept cycle.
- Next state is OUT with `RegWrite_o` = 0 and `read_data_o` = 0.

## Timing
**Reset**
- State IDLE.
- `valid_o`, `dmem_req_valid_o`, `misaligned_o`, `RegWrite_o`, `MemToReg_o` = 0.
- `result_o`, `read_data_o`, `rd_o`, `dmem_*` data = 0.

**Reset mid-operation**
- Drops `dmem_req_valid_o` immediately.
- A later stale response is discarded (state is IDLE).

**Latency**
- Non-memory: `valid_o` the cycle after accept.
- Store: `valid_o` the cycle after `dmem_req_ready_i`.
- Load: `valid_o` the cycle after `dmem_rsp_valid_i`.
- Minimum load latency is 3 cycles after accept when memory is ready immediately and responds the next cycle.

**Handshake rules**
- Outputs stay stable while `valid_o & !ready_i`.
- `ready_o` = 0 in REQ and WAIT.
- `pc_src_o` is never asserted without accept.

## Test plan
- ADD-type accept with `ready_i` = 1, `result_i` = 0x1234, `rd` = 5 → `valid_o` next cycle, `result_o` = 0x1234; back-to-back second op accepted in OUT.
- LB at address 0x1003, memory returns 0x00000000_80000000 after 1 cycle → `dmem_addr_o` = 0x1000, `read_data_o` = 0xFFFF_FFFF_FFFF_FF80 (sign-extended byte 0x80 from lane 3); LBU on the same data → 0x80.
- SH at 0x2006, data 0xABCD, `dmem_req_ready_i` held low 3 cycles → request stable for 4 cycles, `wstrb` = 0xC0, `wdata` = 0xABCD << 48, `ready_o` = 0 throughout.
- LW at 0x3002 → `misaligned_o` pulse, no `dmem_req_valid_o`, `valid_o` with `RegWrite_o` = 0.
- BNE (`I_Type` = 4, `funct3` = 001) with `zero_i` = 0, `BranchPC_i` = 0x400 → `pc_src_o` = 1 and `branch_target_o` = 0x400 in the accept cycle; with `zero_i` = 1 → 0.
- Assert `reset_i` during WAIT, then pulse `dmem_rsp_valid_i` → all outputs 0, state IDLE, no `valid_o`.

Source files
------------

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage: branch resolve, single-outstanding dmem port, load extension

module mem_stage #(
    parameter logic [2:0] BranchType = 3'd4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        zero_i,
    input  logic        ltz_i,
    input  logic [63:0] BranchPC_i,
    input  logic [63:0] result_i,
    input  logic [63:0] MuxRes_i,
    input  logic [4:0]  rd_i,
    input  logic        RegWrite_i,
    input  logic        MemWrite_i,
    input  logic        MemRead_i,
    input  logic        MemToReg_i,
    input  logic [2:0]  funct3_i,
    input  logic [2:0]  I_Type_i,
    output logic        pc_src_o,
    output logic [63:0] branch_target_o,
    output logic        dmem_req_valid_o,
    input  logic        dmem_req_ready_i,
    output logic        dmem_we_o,
    output logic [63:0] dmem_addr_o,
    output logic [63:0] dmem_wdata_o,
    output logic [7:0]  dmem_wstrb_o,
    input  logic        dmem_rsp_valid_i,
    input  logic [63:0] dmem_rdata_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [63:0] result_o,
    output logic [63:0] read_data_o,
    output logic [4:0]  rd_o,
    output logic        RegWrite_o,
    output logic        MemToReg_o,
    output logic        misaligned_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] result_q, result_d;
    logic [63:0] read_data_q, read_data_d;
    logic [4:0]  rd_q, rd_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [2:0]  lane_q, lane_d;
    logic        we_q, we_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;

    logic        accept;
    logic        mem_op;
    logic        mis_in;
    logic [2:0]  lane_in;
    logic [2:0]  align_mask;
    logic [7:0]  size_mask;
    logic        cond;
    logic [63:0] lane_data;
    logic [63:0] load_ext;

    assign ready_o    = (state_q == S_IDLE) || ((state_q == S_OUT) && ready_i);
    assign accept     = valid_i && ready_o;
    assign mem_op     = MemRead_i || MemWrite_i;
    assign lane_in    = result_i[2:0];
    // Low address bits that must be zero for the access size selected by funct3[1:0].
    assign align_mask = {funct3_i[1] & funct3_i[0], funct3_i[1], funct3_i[1] | funct3_i[0]};
    assign mis_in     = mem_op && ((lane_in & align_mask) != 3'b000);

    always_comb begin
        size_mask = 8'h01;
        case (funct3_i[1:0])
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        case (funct3_i)
            3'b000:          cond = zero_i;
            3'b001:          cond = !zero_i;
            3'b100, 3'b110:  cond = ltz_i;
            3'b101, 3'b111:  cond = !ltz_i;
            default:         cond = 1'b0;
        endcase
    end

    assign pc_src_o        = accept && (I_Type_i == BranchType) && cond;
    assign branch_target_o = BranchPC_i;
    assign misaligned_o    = accept && mis_in;

    assign lane_data = dmem_rdata_i >> {lane_q, 3'b000};

    always_comb begin
        load_ext = lane_data;
        case (funct3_q)
            3'b000:  load_ext = {{56{lane_data[7]}}, lane_data[7:0]};
            3'b100:  load_ext = {56'd0, lane_data[7:0]};
            3'b001:  load_ext = {{48{lane_data[15]}}, lane_data[15:0]};
            3'b101:  load_ext = {48'd0, lane_data[15:0]};
            3'b010:  load_ext = {{32{lane_data[31]}}, lane_data[31:0]};
            3'b110:  load_ext = {32'd0, lane_data[31:0]};
            default: load_ext = lane_data;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        result_d     = result_q;
        read_data_d  = read_data_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        funct3_d     = funct3_q;
        lane_d       = lane_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;

        case (state_q)
            S_REQ: begin
                if (dmem_req_ready_i) begin
                    state_d = we_q ? S_OUT : S_WAIT;
                end
            end
            S_WAIT: begin
                if (dmem_rsp_valid_i) begin
                    read_data_d = load_ext;
                    state_d     = S_OUT;
                end
            end
            S_OUT: begin
                if (ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = state_q;
        endcase

        // Accept is only possible in IDLE or a draining OUT, so it overrides the above.
        if (accept) begin
            result_d     = result_i;
            read_data_d  = 64'd0;
            rd_d         = rd_i;
            reg_write_d  = RegWrite_i && !mis_in;
            mem_to_reg_d = MemToReg_i;
            funct3_d     = funct3_i;
            lane_d       = lane_in;
            we_d         = MemWrite_i;
            addr_d       = {result_i[63:3], 3'b000};
            wdata_d      = MuxRes_i << {lane_in, 3'b000};
            wstrb_d      = size_mask << lane_in;
            state_d      = (mem_op && !mis_in) ? S_REQ : S_OUT;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            result_q     <= 64'd0;
            read_data_q  <= 64'd0;
            rd_q         <= 5'd0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            funct3_q     <= 3'd0;
            lane_q       <= 3'd0;
            we_q         <= 1'b0;
            addr_q       <= 64'd0;
            wdata_q      <= 64'd0;
            wstrb_q      <= 8'd0;
        end else begin
            state_q      <= state_d;
            result_q     <= result_d;
            read_data_q  <= read_data_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            funct3_q     <= funct3_d;
            lane_q       <= lane_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
        end
    end

    assign dmem_req_valid_o = (state_q == S_REQ);
    assign dmem_we_o        = we_q;
    assign dmem_addr_o      = addr_q;
    assign dmem_wdata_o     = wdata_q;
    assign dmem_wstrb_o     = wstrb_q;
    assign valid_o          = (state_q == S_OUT);
    assign result_o         = result_q;
    assign read_data_o      = read_data_q;
    assign rd_o             = rd_q;
    assign RegWrite_o       = reg_write_q;
    assign MemToReg_o       = mem_to_reg_q;

endmodule
